// File: rtl/lut_mult_seq_if.sv
// Handshake and operand bundle for the lut_mult_seq sequential nibble multiplier.
interface lut_mult_seq_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  modport master (
    output start, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/lut_mult_seq.sv
// 8x8 unsigned multiplier built from four 4x4 nibble partial products, one per CALC cycle.
// Result appears one cycle after the fourth CALC edge and is held until the next operation.
module lut_mult_seq (
  input  logic           clk,
  input  logic           rst_n,
  lut_mult_seq_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] p_q, p_d;

  logic [3:0]  a_nib, b_nib;
  logic [7:0]  pp;
  logic [3:0]  sh_amt;
  logic [15:0] pp_sh;
  logic [15:0] acc_sum;
  logic        last_step;

  // 4-bit increment; the carry-out is not needed since the count stops at 3.
  function automatic logic [3:0] inc4(input logic [3:0] x);
    return x + 4'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      acc_q   <= 16'h0000;
      cnt_q   <= 4'h0;
      p_q     <= 16'h0000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign last_step = (cnt_q == 4'd3);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StCalc;
      StCalc:  if (last_step) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Step k selects a nibble with k[1] and b nibble with k[0]; weight is 4*(k[1]+k[0]).
  always_comb begin
    a_nib   = cnt_q[1] ? a_q[7:4] : a_q[3:0];
    b_nib   = cnt_q[0] ? b_q[7:4] : b_q[3:0];
    pp      = {4'h0, a_nib} * {4'h0, b_nib};
    sh_amt  = {cnt_q[1] & cnt_q[0], cnt_q[1] ^ cnt_q[0], 2'b00};
    pp_sh   = {8'h00, pp} << sh_amt;
    acc_sum = acc_q + pp_sh;
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    p_d   = p_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d   = bus.a;
          b_d   = bus.b;
          acc_d = 16'h0000;
          cnt_d = 4'h0;
        end
      end
      StCalc: begin
        acc_d = acc_sum;
        cnt_d = inc4(cnt_q);
        if (last_step) p_d = acc_sum;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == StCalc);
    bus.done = (state_q == StDone);
    bus.p    = p_q;
  end

endmodule

// File: tb/tb_lut_mult_seq.sv
// Directed and swept checks of lut_mult_seq: products, busy/done timing, ignored starts, reset abort.
module tb_lut_mult_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  lut_mult_seq_if bus ();

  lut_mult_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // One operation from IDLE: start pulse, 4 busy cycles, done pulse, then p held in IDLE.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] ep,
                       input bit full);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (full || i == 0) begin
        check("busy_calc", {31'b0, bus.busy}, 32'd1);
        check("done_calc", {31'b0, bus.done}, 32'd0);
      end else if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        check("calc_flags", {30'b0, bus.busy, bus.done}, 32'd2);
      end
      @(negedge clk);
    end
    check("done_pulse", {30'b0, bus.busy, bus.done}, 32'd1);
    check("p_value", {16'b0, bus.p}, {16'b0, ep});
    @(negedge clk);
    check("idle_after", {30'b0, bus.busy, bus.done}, 32'd0);
    if (full) check("p_hold", {16'b0, bus.p}, {16'b0, ep});
  endtask

  initial begin
    int done_cnt;
    logic [7:0] ra, rb;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;

    vecs[0] = '{8'h12, 8'h34, 16'h03A8};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hFF, 16'h0000};
    vecs[3] = '{8'hFF, 8'h00, 16'h0000};
    vecs[4] = '{8'h01, 8'h01, 16'h0001};
    vecs[5] = '{8'h0F, 8'h10, 16'h00F0};
    vecs[6] = '{8'hA5, 8'h5A, 16'h3A02};
    vecs[7] = '{8'h7F, 8'h81, 16'h3FFF};

    #1;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_p", {16'b0, bus.p}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].p, 1'b1);

    // Start and operand changes during CALC/DONE must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h0F;
    bus.b     = 8'h10;
    @(negedge clk);
    bus.a = 8'hAA;
    bus.b = 8'hBB;
    for (int i = 0; i < 4; i++) begin
      check("ign_busy", {30'b0, bus.busy, bus.done}, 32'd2);
      @(negedge clk);
    end
    check("ign_done", {30'b0, bus.busy, bus.done}, 32'd1);
    check("ign_p", {16'b0, bus.p}, 32'h00F0);
    bus.start = 1'b0;
    @(negedge clk);
    check("ign_idle", {30'b0, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    check("ign_noqueue", {30'b0, bus.busy, bus.done}, 32'd0);
    check("ign_p_hold", {16'b0, bus.p}, 32'h00F0);

    // Reset on the 2nd CALC cycle aborts with no done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_pre_busy", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_p", {16'b0, bus.p}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_p_hold", {16'b0, bus.p}, 32'd0);

    // Start held high: one operation every 6 cycles.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h80;
    bus.b     = 8'h02;
    done_cnt  = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      check("held_done", {31'b0, bus.done}, {31'b0, (i >= 5) && ((i - 5) % 6 == 0)});
      if (bus.busy && bus.done) check("busy_done_excl", 32'd1, 32'd0);
      if (bus.done) begin
        done_cnt++;
        check("held_p", {16'b0, bus.p}, 32'h0100);
      end
    end
    check("held_count", done_cnt, 32'd5);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);

    // Randomized sweep against a*b with timing checks.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      do_op(ra, rb, 16'(ra) * 16'(rb), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/lut_mult_seq.md
LUT_MULT_SEQ -- requirements
Module: lut_mult_seq

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits, nibble width at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 a  input  8  multiplicand; captured on the accepting edge.
REQ-006 b  input  8  multiplier; captured on the accepting edge.
REQ-007 busy  output  1  high while in CALC.
REQ-008 done  output  1  one-cycle pulse; p valid.
REQ-009 p  output  16  unsigned product a*b; held until the next accepted start.

Function
REQ-010 The block SHALL implement three states: IDLE, CALC, DONE.
REQ-011 IDLE with start=1 at an edge: the block SHALL capture a and b, clear acc and step count, and move to CALC.
REQ-012 IDLE with start=0: the block SHALL stay in IDLE.
REQ-013 CALC: the block SHALL run exactly 4 cycles, with step k = 0,1,2,3 held in a 4-bit counter.
REQ-014 Each CALC cycle, acc SHALL accumulate the partial product pp_k = a_nib[k[1]] * b_nib[k[0]].
REQ-015 pp_k is the 8-bit product of two 4-bit nibbles; it SHALL be left-shifted by 4*(k[1]+k[0]) and added into the 16-bit acc.
REQ-016 Nibble 0 is bits [3:0]; nibble 1 is bits [7:4].
REQ-017 Carry-out of bit 15 SHALL be discarded; it cannot occur for valid 8x8 operands.
REQ-018 The step counter SHALL advance by one per CALC cycle using the team's 4-bit increment block, with Co unused.
REQ-019 Counter wrap beyond 3 SHALL never be observed, because CALC exits when the count is 3.
REQ-020 On the CALC edge with k=3, the block SHALL load p with acc+pp_3 and move to DONE.
REQ-021 DONE: done SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-022 Latency: if start is accepted at edge E0, done SHALL be high in the cycle following edge E0+4.
REQ-023 busy SHALL be 1 exactly in CALC, i.e. the 4 cycles following E0; busy and done SHALL never be high together.
REQ-024 start asserted in CALC or DONE SHALL be ignored, with no queuing, no operand capture and no effect on p.
REQ-025 start held high continuously SHALL be accepted in each IDLE cycle, giving one operation every 6 cycles.
REQ-026 Changes to a or b after the accepting edge SHALL not affect the running result.
REQ-027 p SHALL change only on the CALC k=3 edge and on reset; between operations it SHALL hold its last value.
REQ-028 Products SHALL be unsigned; a=0 or b=0 SHALL yield 0 through the normal 4-cycle flow, with no early exit.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, p=16'h0000, acc=0, count=0, and operand registers to 0.
REQ-030 Reset during CALC or DONE SHALL abort the operation, with no done pulse and p=0.
REQ-031 The first start is accepted at the first rising edge with rst_n=1 and start=1.

Verification
REQ-032 a=8'h12, b=8'h34, one-cycle start -> busy high 4 cycles, then done pulse with p=16'h03A8.
REQ-033 a=8'hFF, b=8'hFF -> p=16'hFE01 at done; a=8'h00, b=8'hFF -> p=16'h0000, still after the 4-cycle flow.
REQ-034 Start with a=8'h0F, b=8'h10; during CALC, drive a=8'hAA, b=8'hBB with start=1 -> single done, p=16'h00F0, second start ignored.
REQ-035 Start, then rst_n low for one cycle on the 2nd CALC cycle -> busy=0, done=0 and p=0 immediately; no done pulse follows.
REQ-036 start held high, operands fixed at a=8'h80, b=8'h02 -> done pulses every 6 cycles, p=16'h0100 each time.
REQ-037 A randomized sweep of 1000 operand pairs SHALL be checked against a*b, together with the busy/done timing of REQ-022 and REQ-023.
